// File: rtl/pcie_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pcie_tx_arbiter_if
// Purpose  : Request/grant bundle between the Tx arbiter and its clients.
// Revision : 1.0 - initial release
// ============================================================================
interface pcie_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] user_req_i;
    logic [NUM_REQ-1:0] user_pkt_done_i;
    logic [NUM_REQ-1:0] user_gnt_o;
    logic               intr_req_i;
    logic               intr_gnt_o;
    logic               intr_done_i;
    logic               intr_req_done_o;
    logic               busy_o;
    logic [NUM_REQ-1:0] err_o;
    logic [NUM_REQ-1:0] err_clr_i;

    // Arbiter side
    modport slave (
        input  user_req_i,
        input  user_pkt_done_i,
        output user_gnt_o,
        input  intr_req_i,
        output intr_gnt_o,
        input  intr_done_i,
        output intr_req_done_o,
        output busy_o,
        output err_o,
        input  err_clr_i
    );

    // Requester / Tx engine side
    modport master (
        output user_req_i,
        output user_pkt_done_i,
        input  user_gnt_o,
        output intr_req_i,
        input  intr_gnt_o,
        output intr_done_i,
        input  intr_req_done_o,
        input  busy_o,
        input  err_o,
        output err_clr_i
    );
endinterface
`default_nettype wire

// File: rtl/pcie_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_tx_arbiter
// Purpose  : Shares the PCIe Tx engine between four DMA stream requesters and
//            the interrupt path (round-robin users, interrupt priority).
// Revision : 1.0 - initial release
// ============================================================================
module pcie_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_PKTS = 4,
    parameter int TIMEOUT    = 4096
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    pcie_tx_arbiter_if.slave   bus
);

    localparam int              c_IDX_W       = $clog2(NUM_REQ);
    localparam bit              c_WD_EN       = (TIMEOUT != 0);
    localparam logic [15:0]     c_WD_LAST     = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic [3:0]      c_BURST_LAST  = 4'(BURST_PKTS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_USR = 2'd1,
        ST_GNT_INT = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t                 r_state;
    logic [NUM_REQ-1:0]     r_user_gnt;
    logic                   r_intr_gnt;
    logic                   r_intr_req_done;
    logic                   r_busy;
    logic [NUM_REQ-1:0]     r_err;
    logic [c_IDX_W-1:0]     r_rr_ptr;
    logic [c_IDX_W-1:0]     r_gnt_idx;
    logic [3:0]             r_burst_cnt;
    logic [15:0]            r_wd_cnt;

    logic                   w_pick_valid;
    logic [c_IDX_W-1:0]     w_pick_idx;
    logic [c_IDX_W-1:0]     w_scan_idx;
    logic                   w_done_g;
    logic                   w_req_g;
    logic [3:0]             w_burst_next;
    logic                   w_wd_expire;
    logic                   w_usr_release;
    logic [NUM_REQ-1:0]     w_err_set;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [c_IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scan from the highest offset down so the nearest request to rr_ptr wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = r_rr_ptr;
        w_scan_idx   = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan_idx = r_rr_ptr + k[c_IDX_W-1:0];
            if (bus.user_req_i[w_scan_idx]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    // Release decision for the currently held user grant.
    always_comb begin
        w_done_g     = bus.user_pkt_done_i[r_gnt_idx];
        w_req_g      = bus.user_req_i[r_gnt_idx];
        w_burst_next = r_burst_cnt + 4'd1;
        w_wd_expire  = c_WD_EN && !w_done_g && (r_wd_cnt == c_WD_LAST);
        if (w_done_g) begin
            w_usr_release = (w_burst_next == c_BURST_LAST) || !w_req_g;
        end else begin
            w_usr_release = !w_req_g || w_wd_expire;
        end
        w_err_set = '0;
        if (r_state == ST_GNT_USR && w_wd_expire) begin
            w_err_set = f_onehot(r_gnt_idx);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= ST_IDLE;
            r_user_gnt      <= '0;
            r_intr_gnt      <= 1'b0;
            r_intr_req_done <= 1'b0;
            r_busy          <= 1'b0;
            r_err           <= '0;
            r_rr_ptr        <= '0;
            r_gnt_idx       <= '0;
            r_burst_cnt     <= '0;
            r_wd_cnt        <= '0;
        end else begin
            r_intr_req_done <= 1'b0;
            // A timeout set in the same cycle as a clear takes precedence.
            r_err           <= (r_err & ~bus.err_clr_i) | w_err_set;

            case (r_state)
                ST_IDLE: begin
                    if (bus.intr_req_i) begin
                        r_intr_gnt <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_GNT_INT;
                    end else if (w_pick_valid) begin
                        r_user_gnt  <= f_onehot(w_pick_idx);
                        r_gnt_idx   <= w_pick_idx;
                        r_busy      <= 1'b1;
                        r_burst_cnt <= '0;
                        r_wd_cnt    <= '0;
                        r_state     <= ST_GNT_USR;
                    end
                end

                ST_GNT_USR: begin
                    if (w_done_g) begin
                        r_burst_cnt <= w_burst_next;
                        r_wd_cnt    <= '0;
                    end else if (c_WD_EN) begin
                        r_wd_cnt    <= r_wd_cnt + 16'd1;
                    end
                    if (w_usr_release) begin
                        r_user_gnt <= '0;
                        r_busy     <= 1'b0;
                        r_rr_ptr   <= r_gnt_idx + 1'b1;
                        r_state    <= ST_GAP;
                    end
                end

                ST_GNT_INT: begin
                    if (bus.intr_done_i) begin
                        r_intr_req_done <= 1'b1;
                        r_intr_gnt      <= 1'b0;
                        r_busy          <= 1'b0;
                        r_state         <= ST_GAP;
                    end else if (!bus.intr_req_i) begin
                        r_intr_gnt      <= 1'b0;
                        r_busy          <= 1'b0;
                        r_state         <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.user_gnt_o      = r_user_gnt;
    assign bus.intr_gnt_o      = r_intr_gnt;
    assign bus.intr_req_done_o = r_intr_req_done;
    assign bus.busy_o          = r_busy;
    assign bus.err_o           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_tx_arbiter
// Purpose  : Directed self-checking bench for pcie_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_tx_arbiter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [3:0] exp_gnt;

    pcie_tx_arbiter_if #(.NUM_REQ(4)) if_a ();
    pcie_tx_arbiter_if #(.NUM_REQ(4)) if_b ();

    // Single-packet bursts
    pcie_tx_arbiter #(.NUM_REQ(4), .BURST_PKTS(1), .TIMEOUT(16)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_a)
    );

    // Four-packet bursts
    pcie_tx_arbiter #(.NUM_REQ(4), .BURST_PKTS(4), .TIMEOUT(16)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        if_a.user_req_i = '0; if_a.user_pkt_done_i = '0; if_a.intr_req_i = 1'b0;
        if_a.intr_done_i = 1'b0; if_a.err_clr_i = '0;
        if_b.user_req_i = '0; if_b.user_pkt_done_i = '0; if_b.intr_req_i = 1'b0;
        if_b.intr_done_i = 1'b0; if_b.err_clr_i = '0;
        repeat (3) tick();

        chk("rst_user_gnt", 16'(if_a.user_gnt_o), 16'h0);
        chk("rst_intr_gnt", 16'(if_a.intr_gnt_o), 16'h0);
        chk("rst_busy", 16'(if_a.busy_o), 16'h0);
        chk("rst_err", 16'(if_a.err_o), 16'h0);
        chk("rst_intr_done", 16'(if_a.intr_req_done_o), 16'h0);

        // Alternating grants 0,2,0,2 with single-packet bursts
        rst = 1'b0;
        if_a.user_req_i = 4'b0101;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_gnt = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            chk("t1_gnt_c0", 16'(if_a.user_gnt_o), 16'(exp_gnt));
            chk("t1_busy_c0", 16'(if_a.busy_o), 16'h1);
            tick();
            chk("t1_gnt_c1", 16'(if_a.user_gnt_o), 16'(exp_gnt));
            tick();
            chk("t1_gnt_c2", 16'(if_a.user_gnt_o), 16'(exp_gnt));
            if_a.user_pkt_done_i = exp_gnt;
            tick();
            if_a.user_pkt_done_i = '0;
            chk("t1_gap_gnt", 16'(if_a.user_gnt_o), 16'h0);
            chk("t1_gap_busy", 16'(if_a.busy_o), 16'h0);
            tick();
            chk("t1_idle_gnt", 16'(if_a.user_gnt_o), 16'h0);
            tick();
        end
        if_a.user_req_i = '0;

        // Burst of four packets on requester 1, then re-grant to the same requester
        if_b.user_req_i = 4'b0010;
        tick();
        for (int p = 0; p < 4; p++) begin
            chk("t2_gnt_a", 16'(if_b.user_gnt_o), 16'h2);
            tick();
            chk("t2_gnt_b", 16'(if_b.user_gnt_o), 16'h2);
            tick();
            chk("t2_gnt_c", 16'(if_b.user_gnt_o), 16'h2);
            if_b.user_pkt_done_i = 4'b0010;
            tick();
            if_b.user_pkt_done_i = '0;
        end
        chk("t2_gap_gnt", 16'(if_b.user_gnt_o), 16'h0);
        chk("t2_gap_busy", 16'(if_b.busy_o), 16'h0);
        tick();
        chk("t2_idle_gnt", 16'(if_b.user_gnt_o), 16'h0);
        tick();
        chk("t2_regrant", 16'(if_b.user_gnt_o), 16'h2);
        if_b.user_req_i = '0;
        tick();
        chk("t2_withdraw", 16'(if_b.user_gnt_o), 16'h0);
        tick();

        // Interrupt beats simultaneous user requests
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_b.intr_req_i = 1'b1;
        if_b.user_req_i = 4'b1111;
        tick();
        chk("t3_intr_gnt", 16'(if_b.intr_gnt_o), 16'h1);
        chk("t3_user_gnt", 16'(if_b.user_gnt_o), 16'h0);
        chk("t3_busy", 16'(if_b.busy_o), 16'h1);
        if_b.intr_done_i = 1'b1;
        tick();
        if_b.intr_done_i = 1'b0;
        if_b.intr_req_i  = 1'b0;
        chk("t3_done_pulse", 16'(if_b.intr_req_done_o), 16'h1);
        chk("t3_intr_drop", 16'(if_b.intr_gnt_o), 16'h0);
        chk("t3_gap_user", 16'(if_b.user_gnt_o), 16'h0);
        tick();
        chk("t3_done_clear", 16'(if_b.intr_req_done_o), 16'h0);
        tick();
        chk("t3_user0", 16'(if_b.user_gnt_o), 16'h1);
        if_b.user_req_i = '0;
        tick();
        chk("t3_release", 16'(if_b.user_gnt_o), 16'h0);
        tick();

        // Watchdog on requester 3; clear in the expiry cycle must lose
        if_b.user_req_i = 4'b1000;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("t4_gnt_hold", 16'(if_b.user_gnt_o), 16'h8);
            if (i == 0) chk("t4_err_pre", 16'(if_b.err_o), 16'h0);
            if (i == 15) if_b.err_clr_i = 4'b1000;
            tick();
        end
        if_b.err_clr_i  = '0;
        if_b.user_req_i = '0;
        chk("t4_gnt_drop", 16'(if_b.user_gnt_o), 16'h0);
        chk("t4_err_set", 16'(if_b.err_o), 16'h8);
        tick();
        chk("t4_err_sticky", 16'(if_b.err_o), 16'h8);
        if_b.err_clr_i = 4'b1000;
        tick();
        if_b.err_clr_i = '0;
        chk("t4_err_clr", 16'(if_b.err_o), 16'h0);

        // Reset during a user grant
        if_b.user_req_i = 4'b0100;
        tick();
        chk("t5_gnt2", 16'(if_b.user_gnt_o), 16'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_gnt", 16'(if_b.user_gnt_o), 16'h0);
        chk("t5_rst_busy", 16'(if_b.busy_o), 16'h0);
        chk("t5_rst_done", 16'(if_b.intr_req_done_o), 16'h0);
        if_b.user_req_i = 4'b0110;
        tick();
        chk("t5_gnt1", 16'(if_b.user_gnt_o), 16'h2);

        // Interrupt arriving mid-grant waits, then wins; withdrawal gives no pulse
        if_b.intr_req_i = 1'b1;
        tick();
        chk("t6_no_preempt", 16'(if_b.user_gnt_o), 16'h2);
        chk("t6_intr_wait", 16'(if_b.intr_gnt_o), 16'h0);
        if_b.user_req_i = '0;
        tick();
        chk("t6_gap_user", 16'(if_b.user_gnt_o), 16'h0);
        chk("t6_gap_intr", 16'(if_b.intr_gnt_o), 16'h0);
        tick();
        chk("t6_idle_intr", 16'(if_b.intr_gnt_o), 16'h0);
        tick();
        chk("t6_intr_gnt", 16'(if_b.intr_gnt_o), 16'h1);
        chk("t6_user_off", 16'(if_b.user_gnt_o), 16'h0);
        if_b.intr_req_i = 1'b0;
        tick();
        chk("t6_intr_drop", 16'(if_b.intr_gnt_o), 16'h0);
        chk("t6_no_pulse", 16'(if_b.intr_req_done_o), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_tx_arbiter.md
Name: pcie_tx_arbiter

Overview:
- Shares the single PCIe Tx engine between four user-to-system DMA stream controllers (USER1..USER4) and the interrupt requester from the global register file.
- Round-robin grant among user requesters. Interrupts have priority at arbitration points.
- Per-grant packet burst limit and a per-grant watchdog with sticky error flags.
- Sits between the stream controllers / register file and the Tx engine.

Parameters:
- NUM_REQ, 4, number of user requesters (fixed at 4 for this revision).
- BURST_PKTS, 4, max consecutive packets per user grant (1..15).
- TIMEOUT, 4096, cycles a grant may last without a packet done; 0 disables the watchdog. Must be < 2^16.

Ports:
- clk_i  input  1  250 MHz PCIe user clock.
- rst_i  input  1  reset, synchronous, active-high.
- user_req_i  input  4  bit n = requester n has a TLP ready; held until served or withdrawn.
- user_pkt_done_i  input  4  bit n pulse = Tx engine accepted the last beat of requester n's TLP.
- user_gnt_o  output  4  one-hot registered grant to user requesters.
- intr_req_i  input  1  level interrupt request from the register file.
- intr_gnt_o  output  1  registered grant of the Tx engine to the interrupt path.
- intr_done_i  input  1  pulse from the Tx engine: interrupt message sent.
- intr_req_done_o  output  1  one-cycle pulse to the register file, equal to intr_done_i registered while intr_gnt_o is high.
- busy_o  output  1  high whenever any grant is active.
- err_o  output  4  sticky per-requester watchdog-timeout flags.
- err_clr_i  input  4  bit n pulse clears err_o[n].

Behaviour:
- Reset (rst_i high at clk edge): state=IDLE, user_gnt_o=0, intr_gnt_o=0, intr_req_done_o=0, busy_o=0, err_o=0, rr_ptr=0, burst_cnt=0, wd_cnt=0. Reset mid-grant drops the grant the next cycle with no done pulse.
- States:
  - IDLE: arbitrate.
  - GNT_USR: a user grant is held.
  - GNT_INT: the interrupt grant is held.
  - GAP: one dead cycle after every grant release. No grant is asserted in GAP. GAP->IDLE is unconditional.
- Arbitration in IDLE, with the decision registered:
  - If intr_req_i: intr_gnt_o=1 next cycle, go to GNT_INT.
  - Else if any user_req_i: choose the first set bit searching rr_ptr, rr_ptr+1, ... mod 4. Assert that grant next cycle, go to GNT_USR, burst_cnt=0, wd_cnt=0.
  - Else stay in IDLE.
  - Latency from request to grant is 1 cycle from IDLE.
- No preemption. An interrupt arriving during GNT_USR waits for the next IDLE and then wins over user requests.
- GNT_USR, granted index g:
  - user_pkt_done_i[g]: burst_cnt+1 and wd_cnt=0. Release (go to GAP) if burst_cnt+1==BURST_PKTS or user_req_i[g]==0 in the same cycle. Otherwise keep the grant.
  - user_req_i[g] low with no done: release.
  - Done pulses on non-granted bits are ignored.
  - On release: rr_ptr=(g+1) mod 4, and the grant deasserts in the next cycle.
- Watchdog, while in GNT_USR with TIMEOUT!=0:
  - wd_cnt increments each cycle without user_pkt_done_i[g].
  - When wd_cnt reaches TIMEOUT-1: release, set err_o[g], rr_ptr=(g+1) mod 4.
  - If err_clr_i[g] and the set occur in the same cycle, the set wins.
- GNT_INT:
  - On intr_done_i: pulse intr_req_done_o next cycle, drop intr_gnt_o, go to GAP.
  - intr_req_i dropping without done: release to GAP, no pulse.
  - The interrupt path has no watchdog.
- Grants are always one-hot or zero. user_gnt_o and intr_gnt_o are never high together.
- busy_o = |user_gnt_o | intr_gnt_o, registered.

Test Plan:
- Reset, then user_req_i=4'b0101 held, one done per grant 2 cycles after grant → grants alternate 0,2,0,2 with one GAP cycle between grants; with BURST_PKTS=1 each grant lasts exactly 3 cycles.
- BURST_PKTS=4, req[1] held, done every 3 cycles → grant[1] held through 4 dones, then GAP; rr_ptr=2; with req[1] still high and no other requests, grant[1] reasserts 2 cycles after release.
- intr_req_i and user_req_i=4'b1111 asserted together in IDLE → intr_gnt_o first; intr_done_i → intr_req_done_o one-cycle pulse, then user grant[0].
- TIMEOUT=16, req[3] held, no done → grant[3] drops 16 cycles after grant, err_o=4'b1000; err_clr_i[3] pulse → err_o=0.
- rst_i pulsed during GNT_USR with grant[2] → user_gnt_o=0 next cycle, rr_ptr=0, the next request of 4'b0110 grants index 1.
